// File: rtl/pmem_arbiter.sv
// Fixed-priority arbiter sharing one 256-bit memory port between I-cache and D-cache.
// One line transaction at a time; D wins ties, and a one-cycle RELEASE separates transactions.
module pmem_arbiter (
  input  logic         clk,
  input  logic         rst,

  input  logic         i_pmem_read,
  input  logic [31:0]  i_pmem_address,
  output logic [255:0] i_pmem_rdata,
  output logic         i_pmem_resp,

  input  logic         d_pmem_read,
  input  logic         d_pmem_write,
  input  logic [31:0]  d_pmem_address,
  input  logic [255:0] d_pmem_wdata,
  output logic [255:0] d_pmem_rdata,
  output logic         d_pmem_resp,

  output logic         pmem_read,
  output logic         pmem_write,
  output logic [31:0]  pmem_address,
  output logic [255:0] pmem_wdata,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp
);

  typedef enum logic [1:0] {
    IDLE,
    I_SERVE,
    D_SERVE,
    RELEASE
  } state_t;

  state_t state;

  // Memory-side outputs are driven only from registers captured at the grant edge,
  // so requester inputs never reach the memory port combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (d_pmem_read || d_pmem_write) begin
            state        <= D_SERVE;
            pmem_address <= d_pmem_address;
            pmem_wdata   <= d_pmem_wdata;
            // Write-back wins when the D-cache raises both strobes.
            pmem_write   <= d_pmem_write;
            pmem_read    <= ~d_pmem_write;
          end else if (i_pmem_read) begin
            state        <= I_SERVE;
            pmem_address <= i_pmem_address;
            pmem_wdata   <= '0;
            pmem_write   <= 1'b0;
            pmem_read    <= 1'b1;
          end
        end
        I_SERVE, D_SERVE: begin
          if (pmem_resp) begin
            state      <= RELEASE;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
          end
        end
        RELEASE: begin
          state <= IDLE;
        end
        default: begin
          state      <= IDLE;
          pmem_read  <= 1'b0;
          pmem_write <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    i_pmem_rdata = pmem_rdata;
    d_pmem_rdata = pmem_rdata;
    i_pmem_resp  = pmem_resp && (state == I_SERVE);
    d_pmem_resp  = pmem_resp && (state == D_SERVE);
  end

endmodule

// File: doc/pmem_arbiter.md
# pmem_arbiter

Arbitrates the single 256-bit physical-memory port between the instruction cache (fetch-stage misses) and the data cache (MEM-stage misses and write-backs). Sits between both caches and main memory. Serves one cache-line transaction at a time and routes the response only to the granted cache. Data-cache requests take fixed priority, because the MEM-stage instruction is older than the one being fetched.

## Interface
- No parameters; line width fixed at 256 bits, address width at 32 bits.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `i_pmem_read` in 1: I-cache line-fill request.
- `i_pmem_address` in 32: I-cache line address, bits [4:0] = 0.
- `i_pmem_rdata` out 256: fill data to I-cache.
- `i_pmem_resp` out 1: I-cache transaction complete.
- `d_pmem_read` in 1: D-cache line-fill request.
- `d_pmem_write` in 1: D-cache write-back request.
- `d_pmem_address` in 32: D-cache line address, bits [4:0] = 0.
- `d_pmem_wdata` in 256: write-back line.
- `d_pmem_rdata` out 256: fill data to D-cache.
- `d_pmem_resp` out 1: D-cache transaction complete.
- `pmem_read` out 1: memory read strobe.
- `pmem_write` out 1: memory write strobe.
- `pmem_address` out 32: memory line address.
- `pmem_wdata` out 256: memory write line.
- `pmem_rdata` in 256: memory read line.
- `pmem_resp` in 1: memory transaction done, single-cycle pulse.

## Operation
- **States:** IDLE, I_SERVE, D_SERVE, RELEASE. Reset state is IDLE.
- **In IDLE:**
  - If `d_pmem_read` or `d_pmem_write` is high, go to D_SERVE.
  - Else if `i_pmem_read` is high, go to I_SERVE.
  - Else stay in IDLE.
- **Latch on grant:** at the grant edge, register the winner's address, wdata and op.
  - The op is read or write. If `d_pmem_read` and `d_pmem_write` are both high, write wins.
  - While the transaction is outstanding, pmem outputs come from these registers only.
- **I_SERVE:** `pmem_read` = 1. On `pmem_resp` = 1, go to RELEASE.
- **D_SERVE:** `pmem_read` or `pmem_write` = 1 per the latched op. On `pmem_resp` = 1, go to RELEASE.
- **RELEASE:** both strobes low for exactly one cycle, then IDLE. This gives the cache one cycle to drop its request before it can be re-sampled.
- **Response routing:**
  - `i_pmem_resp` = `pmem_resp` while in I_SERVE, else 0.
  - `d_pmem_resp` = `pmem_resp` while in D_SERVE, else 0.
  - Both are combinational (same cycle as `pmem_resp`).
  - `i_pmem_rdata` and `d_pmem_rdata` both equal `pmem_rdata` combinationally; only the resp line qualifies the data.
- **Ignored inputs while serving:**
  - Requests from the non-granted cache are ignored; that cache simply keeps its request high and waits.
  - Deassertion of the granted request mid-service is ignored: the transaction completes and resp is still pulsed.
- **`pmem_resp` outside I_SERVE/D_SERVE:** ignored; no resp is forwarded and the state does not change.
- **Reset values:**
  - `pmem_read`, `pmem_write`, `i_pmem_resp`, `d_pmem_resp` = 0.
  - `pmem_address` = 0, `pmem_wdata` = 0.
  - State = IDLE.
- **Reset mid-transaction:** abandons the transaction. Strobes drop on the cycle after the reset edge and no resp is forwarded.
- **Starvation:** the I-cache may be starved by back-to-back D requests. This is acceptable, since a D miss stalls the whole pipeline.

## Timing
- A request sampled high in IDLE at edge N gives strobe high from cycle N+1.
- `pmem_resp` at cycle M gives a requester resp at cycle M.
- RELEASE occupies cycle M+1; IDLE is re-entered at M+2.
- Earliest next grant is sampled at edge M+2, with its strobe in cycle M+3.
- Minimum turnaround between transactions is 2 idle strobe cycles.
- Per-transaction latency = memory latency + 1 grant cycle.
- Strobes, address and wdata are stable from grant until the `pmem_resp` cycle inclusive.
- No combinational path from requester inputs to pmem outputs.

## Test plan
1. **Reset:** assert `rst` for 2 cycles with all requests high -> all strobes and resps 0, `pmem_address` = 0; first grant strobe appears 1 cycle after `rst` falls, and it is for D.
2. **Single I fill:** `i_pmem_read` = 1, addr 0x0000_0060, memory responds 5 cycles after strobe with rdata 0xA5…A5 ->
   - `pmem_read` = 1 with `pmem_address` = 0x60 throughout;
   - `i_pmem_resp` pulses once with rdata 0xA5…A5;
   - `d_pmem_resp` stays 0;
   - strobe is low in the following cycle.
3. **Simultaneous request:** I read to 0x100 and D read to 0x200 both asserted in the same IDLE cycle ->
   - D serviced first (address 0x200), then RELEASE, IDLE, then I (address 0x100);
   - each resp goes only to its owner.
4. **Write-back then fill:** D write to 0x40 with wdata 0xDEAD…BEEF, then D read to 0x80 ->
   - `pmem_write` with the exact wdata, then `pmem_read` at 0x80;
   - two `d_pmem_resp` pulses;
   - strobes are never both high.
5. **Request change mid-service:** during I_SERVE, change `i_pmem_address` to 0x999 and raise `d_pmem_write` -> `pmem_address` stays at the latched value; D is granted only after RELEASE.
6. **Reset mid-transaction:** assert `rst` while in D_SERVE, and have the memory return `pmem_resp` one cycle later -> strobes 0 after the reset edge, no `d_pmem_resp` pulse, state IDLE.
